// File: rtl/sap2_fetch_sequencer.sv
// SAP-II fetch/jump control sequencer: fetches 1-3 byte instructions, hands off to the
// execute decoder through exec_en/exec_done, and reloads the PC on taken jumps.
module sap2_fetch_sequencer #(
   parameter int unsigned EXEC_TIMEOUT = 8,
   parameter int unsigned CNT_W        = 4
) (
   input  logic       CLK,
   input  logic       nCLR,
   input  logic [1:0] opcode_len,
   input  logic       hlt,
   input  logic       exec_done,
   input  logic       jump_take,
   output logic       pc_nCLR,
   output logic       Cp,
   output logic       Ep,
   output logic       nLp,
   output logic       nLm,
   output logic       nCE,
   output logic       nLi,
   output logic       nLl,
   output logic       nLh,
   output logic       Eo,
   output logic       exec_en,
   output logic       halted,
   output logic       fault
);

   typedef enum logic [2:0] {
      S_CLR, S_ADDR, S_INC, S_MEM, S_DECODE, S_EXEC, S_JUMP, S_HALT
   } state_t;

   localparam bit               TO_EN   = (EXEC_TIMEOUT != 0);
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(EXEC_TIMEOUT - 1);

   state_t           state, state_nx;
   logic [1:0]       idx, idx_nx;
   logic [1:0]       len, len_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic             fault_nx;

   always_ff @(posedge CLK or negedge nCLR) begin
      if (!nCLR) begin
         state <= S_CLR;
         idx   <= '0;
         len   <= '0;
         cnt   <= '0;
         fault <= 1'b0;
      end else begin
         state <= state_nx;
         idx   <= idx_nx;
         len   <= len_nx;
         cnt   <= cnt_nx;
         fault <= fault_nx;
      end
   end

   always_comb begin
      state_nx = state;
      idx_nx   = idx;
      len_nx   = len;
      cnt_nx   = '0;
      fault_nx = 1'b0;
      case (state)
         S_CLR:  state_nx = S_ADDR;
         S_ADDR: state_nx = S_INC;
         S_INC:  state_nx = S_MEM;
         S_MEM: begin
            if (idx == 2'd0) begin
               state_nx = S_DECODE;
            end else if (idx < len - 2'd1) begin
               idx_nx   = idx + 2'd1;
               state_nx = S_ADDR;
            end else begin
               idx_nx   = '0;
               state_nx = S_EXEC;
            end
         end
         S_DECODE: begin
            // A length code of zero is a 1-byte instruction.
            len_nx = (opcode_len == 2'd0) ? 2'd1 : opcode_len;
            if (hlt) begin
               state_nx = S_HALT;
            end else if (opcode_len <= 2'd1) begin
               state_nx = S_EXEC;
            end else begin
               idx_nx   = 2'd1;
               state_nx = S_ADDR;
            end
         end
         S_EXEC: begin
            cnt_nx = cnt + 1'b1;
            if (exec_done) begin
               cnt_nx   = '0;
               state_nx = jump_take ? S_JUMP : S_ADDR;
            end else if (TO_EN && cnt == TO_LAST) begin
               cnt_nx   = '0;
               fault_nx = 1'b1;
               state_nx = S_ADDR;
            end
         end
         S_JUMP: state_nx = S_ADDR;
         S_HALT: state_nx = S_HALT;
      endcase
   end

   always_comb begin
      pc_nCLR = 1'b1;
      Cp      = 1'b0;
      Ep      = 1'b0;
      nLp     = 1'b1;
      nLm     = 1'b1;
      nCE     = 1'b1;
      nLi     = 1'b1;
      nLl     = 1'b1;
      nLh     = 1'b1;
      Eo      = 1'b0;
      exec_en = 1'b0;
      halted  = 1'b0;
      case (state)
         S_CLR:  pc_nCLR = 1'b0;
         S_ADDR: begin
            Ep  = 1'b1;
            nLm = 1'b0;
         end
         S_INC:  Cp = 1'b1;
         S_MEM: begin
            nCE = 1'b0;
            nLi = (idx != 2'd0);
            nLl = (idx != 2'd1);
            nLh = (idx != 2'd2);
         end
         S_DECODE: ;
         S_EXEC: exec_en = 1'b1;
         S_JUMP: begin
            Eo  = 1'b1;
            nLp = 1'b0;
         end
         S_HALT: halted = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_sap2_fetch_sequencer.sv
// Randomized bench for sap2_fetch_sequencer with a PC/MAR/memory environment and an
// instruction-level reference model predicting every cycle's control word and fetch address.
module tb_sap2_fetch_sequencer;

   localparam int unsigned TO = 8;

   // control word order: {pc_nCLR,Cp,Ep,nLp,nLm,nCE,nLi,nLl,nLh,Eo,exec_en,halted,fault}
   localparam logic [12:0] V_CLR  = 13'b0_0_0_1_1_1_1_1_1_0_0_0_0;
   localparam logic [12:0] V_IDLE = 13'b1_0_0_1_1_1_1_1_1_0_0_0_0;
   localparam logic [12:0] V_ADDR = 13'b1_0_1_1_0_1_1_1_1_0_0_0_0;
   localparam logic [12:0] V_INC  = 13'b1_1_0_1_1_1_1_1_1_0_0_0_0;
   localparam logic [12:0] V_MEMI = 13'b1_0_0_1_1_0_0_1_1_0_0_0_0;
   localparam logic [12:0] V_MEML = 13'b1_0_0_1_1_0_1_0_1_0_0_0_0;
   localparam logic [12:0] V_MEMH = 13'b1_0_0_1_1_0_1_1_0_0_0_0_0;
   localparam logic [12:0] V_EXEC = 13'b1_0_0_1_1_1_1_1_1_0_1_0_0;
   localparam logic [12:0] V_JUMP = 13'b1_0_0_0_1_1_1_1_1_1_0_0_0;
   localparam logic [12:0] V_HALT = 13'b1_0_0_1_1_1_1_1_1_0_0_1_0;
   localparam logic [12:0] V_F    = 13'b0_0_0_0_0_0_0_0_0_0_0_0_1;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic       nCLR;
   logic [1:0] opcode_len;
   logic       hlt, exec_done, jump_take;
   logic       pc_nCLR, Cp, Ep, nLp, nLm, nCE, nLi, nLl, nLh, Eo, exec_en, halted, fault;

   logic [1:0] opcode_len0;
   logic       hlt0, exec_done0, jump_take0;
   logic       pc_nCLR0, Cp0, Ep0, nLp0, nLm0, nCE0, nLi0, nLl0, nLh0, Eo0, exec_en0, halted0, fault0;

   sap2_fetch_sequencer #(.EXEC_TIMEOUT(TO), .CNT_W(4)) dut (
      .CLK(CLK), .nCLR(nCLR), .opcode_len(opcode_len), .hlt(hlt),
      .exec_done(exec_done), .jump_take(jump_take),
      .pc_nCLR(pc_nCLR), .Cp(Cp), .Ep(Ep), .nLp(nLp), .nLm(nLm), .nCE(nCE),
      .nLi(nLi), .nLl(nLl), .nLh(nLh), .Eo(Eo), .exec_en(exec_en),
      .halted(halted), .fault(fault)
   );

   sap2_fetch_sequencer #(.EXEC_TIMEOUT(0), .CNT_W(4)) dut0 (
      .CLK(CLK), .nCLR(nCLR), .opcode_len(opcode_len0), .hlt(hlt0),
      .exec_done(exec_done0), .jump_take(jump_take0),
      .pc_nCLR(pc_nCLR0), .Cp(Cp0), .Ep(Ep0), .nLp(nLp0), .nLm(nLm0), .nCE(nCE0),
      .nLi(nLi0), .nLl(nLl0), .nLh(nLh0), .Eo(Eo0), .exec_en(exec_en0),
      .halted(halted0), .fault(fault0)
   );

   logic [12:0] vout, vout0;
   assign vout  = {pc_nCLR, Cp, Ep, nLp, nLm, nCE, nLi, nLl, nLh, Eo, exec_en, halted, fault};
   assign vout0 = {pc_nCLR0, Cp0, Ep0, nLp0, nLm0, nCE0, nLi0, nLl0, nLh0, Eo0, exec_en0, halted0, fault0};

   function automatic logic [7:0] mem(input logic [15:0] a);
      if (a == 16'h0001) return 8'h15;
      if (a == 16'h0002) return 8'hAC;
      return (a[7:0] * 8'd29) + a[15:8] + 8'h3B;
   endfunction

   // environment: PC, MAR, operand registers and the shared bus
   logic [15:0] pc, mar, wbus;
   logic [7:0]  opl, oph;
   assign wbus = Ep ? pc : (!nCE ? {8'h00, mem(mar)} : (Eo ? {oph, opl} : 16'h0000));

   always @(posedge CLK) begin
      if (!pc_nCLR)  pc <= 16'h0000;
      else if (Cp)   pc <= pc + 16'd1;
      else if (!nLp) pc <= wbus;
      if (!nLm) mar <= wbus;
      if (!nLl) opl <= wbus[7:0];
      if (!nLh) oph <= wbus[7:0];
   end

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [15:0] pc_ref;
   logic [7:0]  opl_ref = 8'h00, oph_ref = 8'h00;
   bit          fault_pend;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic rnd();
      return 1'($urandom);
   endfunction

   task automatic step(input string tag, input logic [12:0] ev, input logic d, input logic t,
                       input bit chk_a, input logic [15:0] a);
      @(negedge CLK);
      check(tag, {19'd0, vout}, {19'd0, ev});
      if (chk_a) check({tag, "_addr"}, {16'd0, wbus}, {16'd0, a});
      exec_done = d;
      jump_take = t;
   endtask

   task automatic do_reset(input string tag);
      #1 nCLR = 1'b0;
      #1 check(tag, {19'd0, vout}, {19'd0, V_CLR});
      @(negedge CLK);
      nCLR       = 1'b1;
      exec_done  = 1'b0;
      pc_ref     = 16'h0000;
      fault_pend = 1'b0;
   endtask

   // One instruction: d = EXEC cycle (0-based) on which exec_done rises; d >= TO never finishes.
   task automatic run_instr(input int unsigned len, input bit h, input int unsigned d, input bit take);
      int unsigned eff = (len == 0) ? 1 : len;
      logic [15:0] a   = pc_ref;
      logic [12:0] v;
      opcode_len = len[1:0];
      hlt        = h;
      v          = V_ADDR | (fault_pend ? V_F : 13'b0);
      fault_pend = 1'b0;
      step("addr", v, rnd(), rnd(), 1, a);
      step("inc", V_INC, rnd(), rnd(), 0, 16'h0);
      step("mem_i", V_MEMI, rnd(), rnd(), 0, 16'h0);
      step("decode", V_IDLE, rnd(), rnd(), 0, 16'h0);
      @(posedge CLK);
      #1 opcode_len = 2'($urandom);
      hlt = rnd();
      if (h) begin
         repeat (20) step("halt", V_HALT, rnd(), rnd(), 0, 16'h0);
         return;
      end
      for (int unsigned k = 1; k < eff; k++) begin
         step("addr_op", V_ADDR, rnd(), rnd(), 1, a + 16'(k));
         step("inc_op", V_INC, rnd(), rnd(), 0, 16'h0);
         if (k == 1) begin
            step("mem_l", V_MEML, rnd(), rnd(), 0, 16'h0);
            opl_ref = mem(a + 16'd1);
         end else begin
            step("mem_h", V_MEMH, rnd(), rnd(), 0, 16'h0);
            oph_ref = mem(a + 16'd2);
         end
      end
      if (d < TO) begin
         for (int unsigned i = 0; i < d; i++) step("exec", V_EXEC, 1'b0, 1'b1, 0, 16'h0);
         step("exec_last", V_EXEC, 1'b1, take, 0, 16'h0);
         if (take) step("jump", V_JUMP, rnd(), rnd(), 0, 16'h0);
         pc_ref = take ? {oph_ref, opl_ref} : a + 16'(eff);
      end else begin
         repeat (TO) step("exec_to", V_EXEC, 1'b0, rnd(), 0, 16'h0);
         fault_pend = 1'b1;
         pc_ref     = a + 16'(eff);
      end
   endtask

   initial begin
      nCLR        = 1'b1;
      opcode_len  = 2'd1;
      hlt         = 1'b0;
      exec_done   = 1'b0;
      jump_take   = 1'b0;
      opcode_len0 = 2'd1;
      hlt0        = 1'b0;
      exec_done0  = 1'b0;
      jump_take0  = 1'b0;

      do_reset("reset");
      run_instr(1, 0, 1, 0);
      run_instr(1, 0, 0, 0);

      do_reset("reset_jmp");
      run_instr(3, 0, 0, 1);
      run_instr(1, 0, 0, 0);

      do_reset("reset_nojmp");
      run_instr(2, 0, 2, 0);
      run_instr(1, 0, 100, 0);
      run_instr(0, 0, 3, 0);

      for (int i = 0; i < 80; i++)
         run_instr($urandom_range(0, 3), 0, $urandom_range(0, 10), rnd());
      run_instr(1, 0, 0, 0);

      // reset while an operand byte is being loaded
      opcode_len = 2'd2;
      hlt        = 1'b0;
      step("addr_r", V_ADDR | (fault_pend ? V_F : 13'b0), 1'b0, 1'b0, 1, pc_ref);
      step("inc_r", V_INC, 1'b0, 1'b0, 0, 16'h0);
      step("mem_i_r", V_MEMI, 1'b0, 1'b0, 0, 16'h0);
      step("decode_r", V_IDLE, 1'b0, 1'b0, 0, 16'h0);
      step("addr_op_r", V_ADDR, 1'b0, 1'b0, 1, pc_ref + 16'd1);
      step("inc_op_r", V_INC, 1'b0, 1'b0, 0, 16'h0);
      step("mem_l_r", V_MEML, 1'b0, 1'b0, 0, 16'h0);
      do_reset("reset_mid_mem");
      run_instr(1, 0, 0, 0);

      run_instr(1, 1, 0, 0);
      do_reset("reset_halt");

      // no-timeout instance stays in EXEC until exec_done
      do_reset("reset_to0");
      repeat (4) @(negedge CLK);
      for (int i = 0; i < 50; i++) begin
         @(negedge CLK);
         check("exec_no_to", {19'd0, vout0}, {19'd0, V_EXEC});
      end
      exec_done0 = 1'b1;
      @(negedge CLK);
      check("exec_no_to_exit", {19'd0, vout0}, {19'd0, V_ADDR});
      exec_done0 = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sap2_fetch_sequencer.md
Name: sap2_fetch_sequencer

Overview:
Moore-style control sequencer for the SAP-II fetch/jump path. Drives the 16-bit program counter (Cp, Ep, nLp, synchronous pc clear), the MAR load, the memory bus enable, the instruction register load and the two operand-byte registers, fetching 1-, 2- or 3-byte instructions. After fetch it hands control to the execute decoder through an exec_en/exec_done handshake, then performs a PC load from WBUS on taken jumps. One clock; reset is asynchronous and active-low (CLK, nCLR).

Parameters:
EXEC_TIMEOUT, 8, max EXEC cycles waiting for exec_done before forced abort; 0 disables the timeout
CNT_W, 4, width of the internal exec cycle counter; must hold EXEC_TIMEOUT

Ports:
CLK  input  1  clock, all state changes on posedge
nCLR  input  1  asynchronous active-low reset
opcode_len  input  2  instruction length from decoder, sampled in DECODE; 1/2/3 bytes, 0 treated as 1
hlt  input  1  decoder flags HLT opcode, sampled in DECODE
exec_done  input  1  execute microsequence finished, sampled in EXEC
jump_take  input  1  jump condition true, sampled with exec_done
pc_nCLR  output  1  synchronous clear to PC (active-low)
Cp  output  1  PC increment
Ep  output  1  PC drives WBUS
nLp  output  1  PC loads from WBUS (active-low)
nLm  output  1  MAR load from WBUS (active-low)
nCE  output  1  memory drives WBUS (active-low)
nLi  output  1  instruction register load (active-low)
nLl  output  1  operand low-byte register load (active-low)
nLh  output  1  operand high-byte register load (active-low)
Eo  output  1  operand registers drive 16-bit jump address onto WBUS
exec_en  output  1  execute phase active
halted  output  1  sequencer stopped on HLT
fault  output  1  one-cycle pulse on exec timeout

Behaviour:
- States: CLR, ADDR, INC, MEM, DECODE, EXEC, JUMP, HALT. Outputs decode from state (plus byte index), so they have no combinational input paths.
- Reset (nCLR low, async): state=CLR, byte index=0, counter=0, fault=0. All outputs inactive except pc_nCLR=0.
- Inactive levels: Cp/Ep/Eo/exec_en/halted/fault=0; nLp/nLm/nCE/nLi/nLl/nLh/pc_nCLR=1.
- CLR: pc_nCLR=0 for exactly one cycle. Next state is ADDR. The PC clears on the same edge.
- ADDR: Ep=1, nLm=0 -> INC.
- INC: Cp=1 -> MEM.
- MEM: nCE=0, plus a load selected by byte index: 0 -> nLi=0, 1 -> nLl=0, 2 -> nLh=0.
- Leaving MEM: index 0 -> DECODE. Index below len-1 -> increment index, go to ADDR. Otherwise -> clear index, go to EXEC.
- DECODE (1 cycle, no bus activity): latch len. If hlt -> HALT. Else if len<=1 -> EXEC. Else index=1 -> ADDR.
- Cp and nLp are never active in the same state; Ep/nCE/Eo are mutually exclusive (single bus driver).
- Fetch latency: 1-byte instruction has exec_en high 4 cycles after leaving ADDR; add 3 cycles per operand byte.
- EXEC: exec_en=1; counter increments each cycle.
  - exec_done=1 and jump_take=1 -> JUMP.
  - exec_done=1 and jump_take=0 -> ADDR.
  - Otherwise, if EXEC_TIMEOUT!=0 and counter reaches EXEC_TIMEOUT-1 -> fault=1 for one cycle, go to ADDR without jumping.
  - Counter clears on exit.
- JUMP: Eo=1, nLp=0 for one cycle; PC loads {high,low} operand -> ADDR.
- HALT: halted=1, all other outputs inactive. Exits only via nCLR.
- jump_take without exec_done is ignored. exec_done outside EXEC is ignored.
- PC wrap FFFFh->0000h is handled by the PC; the sequencer simply continues fetching.
- Reset mid-operation (any state): immediate return to CLR. No partially asserted loads survive the reset.

Test Plan:
- Reset then 1-byte op (len=1, exec_done on 2nd EXEC cycle) -> sequence CLR,ADDR,INC,MEM,DECODE,EXEC,EXEC,ADDR; PC 0000h->0001h; nLi low exactly once.
- 3-byte JMP at 0000h, operands 15h,ACh, exec_done=1, jump_take=1 on 1st EXEC -> nLl then nLh pulsed; JUMP cycle Eo=1,nLp=0; next ADDR puts ACh15h on WBUS.
- 2-byte op with jump_take=1 but exec_done=0, then exec_done=1,jump_take=0 -> no JUMP; returns to ADDR with PC=0002h.
- exec_done never asserted, EXEC_TIMEOUT=8 -> exactly 8 EXEC cycles, fault pulses once, then ADDR; with EXEC_TIMEOUT=0 the sequencer stays in EXEC for 50 cycles.
- hlt=1 at DECODE -> HALT, halted=1 held for 20 cycles with no Cp/Ep; async nCLR low mid-HALT -> CLR immediately (pc_nCLR=0 before the next edge).
- nCLR asserted during operand MEM cycle -> nLl released asynchronously; after release PC is cleared and the first fetch is from 0000h.
